// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - scan codes, item/command encodings and FSM state type for the menu navigator
package menu_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;

   localparam logic [2:0] ITEM_OPEN  = 3'd1;
   localparam logic [2:0] ITEM_SAVE  = 3'd2;
   localparam logic [2:0] ITEM_EXIT  = 3'd3;
   localparam logic [2:0] ITEM_CAPS  = 3'd4;
   localparam logic [2:0] ITEM_COLOR = 3'd5;
   localparam logic [2:0] ITEM_SIZE  = 3'd6;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_OPEN = 2'd1;
   localparam logic [1:0] CMD_SAVE = 2'd2;
   localparam logic [1:0] CMD_EXIT = 2'd3;

   typedef logic [1:0] menu_state_t;
   localparam menu_state_t ST_TEXT     = 2'd0;
   localparam menu_state_t ST_DIALOG   = 2'd1;
   localparam menu_state_t ST_CMD_WAIT = 2'd2;

   typedef struct packed {
      logic left;
      logic right;
      logic up;
      logic down;
      logic enter;
      logic esc;
   } key_act_t;

   // Arrows exist only as extended codes; Enter is accepted from either keypad.
   function automatic key_act_t decode_key(input logic ext, input logic [7:0] code);
      key_act_t k;
      k       = '0;
      k.left  = ext && (code == SC_LEFT);
      k.right = ext && (code == SC_RIGHT);
      k.up    = ext && (code == SC_UP);
      k.down  = ext && (code == SC_DOWN);
      k.enter = (code == SC_ENTER);
      k.esc   = !ext && (code == SC_ESC);
      return k;
   endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// rtl/ps2_make_filter.sv - strips E0/F0 prefixes and passes through make codes only
module ps2_make_filter
   import menu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       make_valid,
   output logic       make_ext,
   output logic [7:0] make_code
);

   logic ext_flag;
   logic brk_flag;
   logic is_prefix;

   assign is_prefix  = (key_code == SC_EXT) || (key_code == SC_BRK);
   // Combinational on the final byte so the consumer can register its outputs on the same edge.
   assign make_valid = key_valid && !is_prefix && !brk_flag;
   assign make_ext   = ext_flag;
   assign make_code  = key_code;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
      end else if (key_valid) begin
         if (key_code == SC_EXT) begin
            ext_flag <= 1'b1;
         end else if (key_code == SC_BRK) begin
            brk_flag <= 1'b1;
         end else begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/menu_nav_ctrl.sv
// rtl/menu_nav_ctrl.sv - keyboard-driven text menu bar with confirmation dialog and command handshake
module menu_nav_ctrl
   import menu_pkg::*;
#(
   parameter int NUM_TOP_ITEMS = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic [2:0] item_selector,
   output logic       window_selector,
   output logic       cmd_valid,
   output logic [1:0] cmd_code,
   input  logic       cmd_ready,
   output logic       caps_on,
   output logic [2:0] color_idx,
   output logic [1:0] size_idx
);

   localparam logic [2:0] LAST_ITEM = 3'(NUM_TOP_ITEMS);

   logic        make_valid;
   logic        make_ext;
   logic [7:0]  make_code;
   key_act_t    act;

   menu_state_t state, state_n;
   logic [2:0]  top_item, top_item_n;
   logic        dlg_item, dlg_item_n;
   logic [1:0]  pending, pending_n;
   logic        caps_n;
   logic [2:0]  color_n;
   logic [1:0]  size_n;
   logic        cmd_valid_n;
   logic [1:0]  cmd_code_n;

   ps2_make_filter u_filter (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .make_valid (make_valid),
      .make_ext   (make_ext),
      .make_code  (make_code)
   );

   assign act = make_valid ? decode_key(make_ext, make_code) : '0;

   always_comb begin
      state_n     = state;
      top_item_n  = top_item;
      dlg_item_n  = dlg_item;
      pending_n   = pending;
      caps_n      = caps_on;
      color_n     = color_idx;
      size_n      = size_idx;
      cmd_valid_n = cmd_valid;
      cmd_code_n  = cmd_code;
      case (state)
         ST_TEXT: begin
            if (act.right) begin
               top_item_n = (top_item == LAST_ITEM) ? ITEM_OPEN : top_item + 3'd1;
            end else if (act.left) begin
               top_item_n = (top_item == ITEM_OPEN) ? LAST_ITEM : top_item - 3'd1;
            end else if (act.enter) begin
               case (top_item)
                  ITEM_OPEN, ITEM_SAVE, ITEM_EXIT: begin
                     // Item numbers 1..3 coincide with the command codes.
                     state_n    = ST_DIALOG;
                     pending_n  = top_item[1:0];
                     dlg_item_n = 1'b0;
                  end
                  ITEM_CAPS:  caps_n  = !caps_on;
                  ITEM_COLOR: color_n = color_idx + 3'd1;
                  ITEM_SIZE:  size_n  = size_idx + 2'd1;
                  default: ;
               endcase
            end
         end
         ST_DIALOG: begin
            if (act.up) begin
               dlg_item_n = 1'b0;
            end else if (act.down) begin
               dlg_item_n = 1'b1;
            end else if (act.enter) begin
               if (!dlg_item) begin
                  state_n     = ST_CMD_WAIT;
                  cmd_valid_n = 1'b1;
                  cmd_code_n  = pending;
               end else begin
                  state_n   = ST_TEXT;
                  pending_n = CMD_NONE;
               end
            end else if (act.esc) begin
               state_n   = ST_TEXT;
               pending_n = CMD_NONE;
            end
         end
         ST_CMD_WAIT: begin
            if (cmd_ready) begin
               state_n     = ST_TEXT;
               cmd_valid_n = 1'b0;
               cmd_code_n  = CMD_NONE;
               pending_n   = CMD_NONE;
            end
         end
         default: begin
            state_n     = ST_TEXT;
            cmd_valid_n = 1'b0;
            cmd_code_n  = CMD_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_TEXT;
         top_item        <= ITEM_OPEN;
         dlg_item        <= 1'b0;
         pending         <= CMD_NONE;
         caps_on         <= 1'b0;
         color_idx       <= 3'd0;
         size_idx        <= 2'd0;
         cmd_valid       <= 1'b0;
         cmd_code        <= CMD_NONE;
         item_selector   <= ITEM_OPEN;
         window_selector <= 1'b1;
      end else begin
         state           <= state_n;
         top_item        <= top_item_n;
         dlg_item        <= dlg_item_n;
         pending         <= pending_n;
         caps_on         <= caps_n;
         color_idx       <= color_n;
         size_idx        <= size_n;
         cmd_valid       <= cmd_valid_n;
         cmd_code        <= cmd_code_n;
         // Renderer outputs follow the next state so they settle on the same edge as the key.
         window_selector <= (state_n != ST_DIALOG);
         item_selector   <= (state_n == ST_DIALOG) ? {2'b00, dlg_item_n} : top_item_n;
      end
   end

endmodule
